// File: rtl/shift_sequencer.sv
// Command sequencer for an external parallel-load/shift register: decodes CLEAR, LOAD,
// SHIFT and LOAD_SHIFT commands into clear/load/shift strobes and returns the shifter contents.
module shift_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_asr,
    output logic             sh_clr_n,
    output logic             sh_load_n,
    output logic             sh_shift,
    output logic             sh_asr,
    output logic [WIDTH-1:0] sh_data,
    input  logic [WIDTH-1:0] sh_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam int unsigned WW = $clog2(WIDTH + 1);
    localparam int unsigned NW = (WW > CNT_W) ? WW : CNT_W;

    localparam logic [1:0] OP_CLEAR      = 2'b00;
    localparam logic [1:0] OP_LOAD       = 2'b01;
    localparam logic [1:0] OP_SHIFT      = 2'b10;
    localparam logic [1:0] OP_LOAD_SHIFT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_LOAD    = 3'd2,
        S_SHIFT   = 3'd3,
        S_CAPTURE = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     cnt_q, cnt_d;
    logic [NW-1:0]     n_eff_c;
    logic [1:0]        op_q;
    logic              asr_q;
    logic              asr_c;
    logic              accept_c;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic              rsp_valid_q, rsp_valid_d;
    logic              cmd_ready_q;
    logic              busy_q;
    logic              sh_clr_n_q;
    logic              sh_load_n_q;
    logic              sh_shift_q;
    logic              sh_asr_q;

    assign accept_c = cmd_valid & cmd_ready_q;
    assign n_eff_c  = (NW'(cmd_count) > NW'(WIDTH)) ? NW'(WIDTH) : NW'(cmd_count);
    assign asr_c    = accept_c ? cmd_asr : asr_q;

    // Next state and shift-count bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    cnt_d = n_eff_c;
                    case (cmd_op)
                        OP_CLEAR:      state_d = S_CLEAR;
                        OP_SHIFT:      state_d = (n_eff_c != '0) ? S_SHIFT : S_CAPTURE;
                        OP_LOAD:       state_d = S_LOAD;
                        OP_LOAD_SHIFT: state_d = S_LOAD;
                        default:       state_d = S_LOAD;
                    endcase
                end
            end
            S_CLEAR:   state_d = S_CAPTURE;
            S_LOAD:    state_d = ((op_q == OP_LOAD_SHIFT) && (cnt_q != '0)) ? S_SHIFT : S_CAPTURE;
            S_SHIFT: begin
                cnt_d = cnt_q - NW'(1);
                if (cnt_q <= NW'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: state_d = S_RESP;
            S_RESP: begin
                // rsp_valid trails entry into RESP by one cycle; only a seen handshake retires it
                if (rsp_valid_q && rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // State, command registers and registered Moore decodes of the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_CLEAR;
            asr_q       <= 1'b0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            sh_clr_n_q  <= 1'b1;
            sh_load_n_q <= 1'b1;
            sh_shift_q  <= 1'b0;
            sh_asr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            if (accept_c) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                asr_q  <= cmd_asr;
            end
            if (state_q == S_CAPTURE) begin
                rsp_data_q <= sh_q;
            end
            cmd_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            sh_clr_n_q  <= (state_d != S_CLEAR);
            sh_load_n_q <= (state_d != S_LOAD);
            sh_shift_q  <= (state_d == S_SHIFT);
            sh_asr_q    <= (state_d == S_SHIFT) & asr_c;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign sh_clr_n  = sh_clr_n_q;
    assign sh_load_n = sh_load_n_q;
    assign sh_shift  = sh_shift_q;
    assign sh_asr    = sh_asr_q;
    assign sh_data   = data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: an 8-bit right shifter model closes the loop,
// directed commands push expected results, a monitor checks each response as it appears.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] cmd_count;
    logic       cmd_asr;
    logic       sh_clr_n;
    logic       sh_load_n;
    logic       sh_shift;
    logic       sh_asr;
    logic [7:0] sh_data;
    logic [7:0] sh_q = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       busy;

    localparam logic [1:0] OP_CLEAR      = 2'b00;
    localparam logic [1:0] OP_LOAD       = 2'b01;
    localparam logic [1:0] OP_SHIFT      = 2'b10;
    localparam logic [1:0] OP_LOAD_SHIFT = 2'b11;

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .cmd_asr   (cmd_asr),
        .sh_clr_n  (sh_clr_n),
        .sh_load_n (sh_load_n),
        .sh_shift  (sh_shift),
        .sh_asr    (sh_asr),
        .sh_data   (sh_data),
        .sh_q      (sh_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External shifter driven by the sequencer strobes
    always @(posedge clk) begin
        if (!sh_clr_n)       sh_q <= 8'h00;
        else if (!sh_load_n) sh_q <= sh_data;
        else if (sh_shift)   sh_q <= sh_asr ? {sh_q[7], sh_q[7:1]} : {1'b0, sh_q[7:1]};
    end

    typedef struct {
        logic [7:0] data;
        int         lat;
        int         shifts;
        int         clrs;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   shift_seen = 0;
    int   clr_seen = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_rsp(input logic [7:0] d, input int lat, input int shifts, input int clrs);
        exp_t x;
        x.data = d; x.lat = lat; x.shifts = shifts; x.clrs = clrs;
        sb.push_back(x);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [3:0] c, input logic a);
        int n = 0;
        @(negedge clk);
        cmd_op = op; cmd_data = d; cmd_count = c; cmd_asr = a; cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc; shift_seen = 0; clr_seen = 0; cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        chk("idle_wait", 32'(busy), 0);
    endtask

    // Monitor: pop the expectation when rsp_valid rises, then check it
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (sh_shift)  shift_seen++;
            if (!sh_clr_n) clr_seen++;
            if (rsp_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_expected", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    chk("shift_cycles", 32'(shift_seen), 32'(e.shifts));
                    chk("clr_cycles", 32'(clr_seen), 32'(e.clrs));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
            prev_valid = rsp_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_CLEAR; cmd_data = 8'h00;
        cmd_count = 4'd0; cmd_asr = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_sh_data", 32'(sh_data), 0);
        chk("rst_sh_clr_n", 32'(sh_clr_n), 1);
        chk("rst_sh_load_n", 32'(sh_load_n), 1);
        chk("rst_sh_shift", 32'(sh_shift), 0);
        chk("rst_sh_asr", 32'(sh_asr), 0);

        // LOAD_SHIFT 0xB5 by 3, logical then arithmetic
        expect_rsp(8'h16, 6, 3, 0);
        issue(OP_LOAD_SHIFT, 8'hB5, 4'd3, 1'b0);
        wait_idle();
        expect_rsp(8'hF6, 6, 3, 0);
        issue(OP_LOAD_SHIFT, 8'hB5, 4'd3, 1'b1);
        wait_idle();

        // Count of 12 saturates at WIDTH
        expect_rsp(8'h00, 11, 8, 0);
        issue(OP_LOAD_SHIFT, 8'hB5, 4'd12, 1'b0);
        wait_idle();
        expect_rsp(8'hFF, 11, 8, 0);
        issue(OP_LOAD_SHIFT, 8'hB5, 4'd12, 1'b1);
        wait_idle();

        // LOAD 0x3C then SHIFT by zero
        expect_rsp(8'h3C, 3, 0, 0);
        issue(OP_LOAD, 8'h3C, 4'd0, 1'b0);
        wait_idle();
        expect_rsp(8'h3C, 2, 0, 0);
        issue(OP_SHIFT, 8'h3C, 4'd0, 1'b0);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("rsp_data_held_idle", 32'(rsp_data), 32'h3C);
        chk("rsp_valid_idle", 32'(rsp_valid), 0);

        // LOAD 0xA5, then CLEAR with the response stalled
        expect_rsp(8'hA5, 3, 0, 0);
        issue(OP_LOAD, 8'hA5, 4'd0, 1'b0);
        wait_idle();
        rsp_ready = 1'b0;
        expect_rsp(8'h00, 3, 0, 1);
        issue(OP_CLEAR, 8'h11, 4'd0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rsp_seen", 32'(rsp_valid), 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                cmd_op = OP_LOAD; cmd_data = 8'h77; cmd_count = 4'd0; cmd_valid = 1'b1;
            end
            if (i == 4) cmd_valid = 1'b0;
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 1);
            chk("stall_rsp_data", 32'(rsp_data), 32'h00);
            chk("stall_cmd_ready", 32'(cmd_ready), 0);
            chk("stall_sh_data", 32'(sh_data), 32'h11);
        end
        rsp_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("ignored_cmd_busy", 32'(busy), 0);
        chk("ignored_cmd_sh_data", 32'(sh_data), 32'h11);

        // Reset during the second cycle of a 5-cycle shift
        issue(OP_SHIFT, 8'h5A, 4'd5, 1'b0);
        @(posedge clk);
        #1;
        chk("abort_mid_shift", 32'(sh_shift), 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_cmd_ready", 32'(cmd_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        chk("abort_sh_shift", 32'(sh_shift), 0);
        chk("abort_sh_data", 32'(sh_data), 0);
        chk("abort_rsp_data", 32'(rsp_data), 0);
        repeat (20) @(negedge clk);
        chk("abort_no_rsp", 32'(rsp_valid), 0);
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, data width of the controlled shift register.
REQ-002 Parameter: CNT_W, default 4, width of the shift-count field.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-007 cmd_op  input  2  op code: 00 CLEAR, 01 LOAD, 10 SHIFT, 11 LOAD_SHIFT.
REQ-008 cmd_data  input  WIDTH  parallel load value.
REQ-009 cmd_count  input  CNT_W  number of shift cycles requested.
REQ-010 cmd_asr  input  1  1 = arithmetic shift (MSB fill), 0 = logical (zero fill).
REQ-011 sh_clr_n  output  1  active-low clear to the shifter.
REQ-012 sh_load_n  output  1  active-low parallel load to the shifter.
REQ-013 sh_shift  output  1  shift enable to the shifter.
REQ-014 sh_asr  output  1  fill-select to the shifter.
REQ-015 sh_data  output  WIDTH  load value to the shifter.
REQ-016 sh_q  input  WIDTH  shifter register contents.
REQ-017 rsp_valid  output  1  result available.
REQ-018 rsp_ready  input  1  result consumed when rsp_valid & rsp_ready at a rising edge.
REQ-019 rsp_data  output  WIDTH  captured shifter contents.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 FSM states SHALL be: IDLE, CLEAR, LOAD, SHIFT, CAPTURE, RESP.
REQ-022 cmd_ready SHALL be 1 only in IDLE; commands offered in any other state are ignored, not queued.
REQ-023 On acceptance the block SHALL register cmd_op, cmd_data, cmd_asr and n_eff = min(cmd_count, WIDTH).
REQ-024 Transitions from IDLE on accept: CLEAR op -> CLEAR; LOAD or LOAD_SHIFT -> LOAD; SHIFT with n_eff>0 -> SHIFT; SHIFT with n_eff=0 -> CAPTURE.
REQ-025 CLEAR SHALL last exactly 1 cycle with sh_clr_n=0, then -> CAPTURE.
REQ-026 LOAD SHALL last exactly 1 cycle with sh_load_n=0; then -> SHIFT if op=LOAD_SHIFT and n_eff>0, else -> CAPTURE.
REQ-027 SHIFT SHALL last exactly n_eff cycles with sh_load_n=1, sh_shift=1, sh_asr=registered cmd_asr; a down-counter tracks remaining shifts; then -> CAPTURE.
REQ-028 Outside CLEAR/LOAD/SHIFT: sh_clr_n=1, sh_load_n=1, sh_shift=0, sh_asr=0.
REQ-029 Control outputs SHALL be Moore decodes of state, glitch-free relative to clk.
REQ-030 sh_data SHALL hold the registered cmd_data from acceptance until the next acceptance.
REQ-031 CAPTURE SHALL last 1 cycle and register sh_q into rsp_data, then -> RESP.
REQ-032 RESP SHALL assert rsp_valid and hold rsp_data stable until rsp_valid & rsp_ready, then -> IDLE.
REQ-033 rsp_data SHALL hold its last value outside RESP until the next CAPTURE.
REQ-034 Latency: with k drive cycles (CLEAR 1, LOAD 1, SHIFT n_eff, LOAD_SHIFT 1+n_eff), rsp_valid SHALL rise k+2 edges after the accept edge.
REQ-035 rsp_ready with rsp_valid low SHALL have no effect.
REQ-036 rsp_ready and cmd_valid both high in RESP: the response completes; the command is not accepted until the following IDLE cycle.

Reset
REQ-037 reset high at a rising edge SHALL force IDLE from any state, including mid-SHIFT, discarding the command and any pending response.
REQ-038 After reset: cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, sh_data=0, sh_clr_n=1, sh_load_n=1, sh_shift=0, sh_asr=0, shift counter=0.
REQ-039 reset SHALL take priority over every handshake in the same cycle.

Verification (bench models an 8-bit shifter driven by sh_* outputs)
REQ-040 LOAD_SHIFT data=0xB5 count=3 asr=0 -> exactly 3 sh_shift cycles; rsp_valid 6 edges after accept; rsp_data=0x16.
REQ-041 Same command with asr=1 -> rsp_data=0xF6.
REQ-042 LOAD_SHIFT data=0xB5 count=12: asr=0 -> exactly 8 shift cycles, rsp_data=0x00; asr=1 -> rsp_data=0xFF.
REQ-043 SHIFT count=0 after a load of 0x3C -> no sh_shift pulse; rsp_valid 2 edges after accept; rsp_data=0x3C.
REQ-044 CLEAR after load of 0xA5 -> one sh_clr_n=0 cycle, rsp_data=0x00; rsp_ready held low 5 cycles -> rsp_valid and rsp_data held, cmd_ready=0 throughout, second cmd_valid ignored.
REQ-045 reset asserted during the 2nd shift cycle of count=5 -> next cycle IDLE, sh_shift=0, rsp_valid=0, cmd_ready=1; no response is ever issued for the aborted command.
